// File: rtl/fft_pingpong_mem_pkg.sv
// Shared FFT definitions used by the ping-pong sample memory and the
// address generator.
//   FFT_DATA_W      : default width of one packed complex sample (re/im)
//   FFT_MAX_ADDR_W  : widest per-bank address that bit_reverse() handles
//   bit_reverse()   : reverses the low 'width' bits of an address and
//                     leaves every bit above them at zero
package fft_pingpong_mem_pkg;

    localparam int FFT_DATA_W     = 32;
    localparam int FFT_MAX_ADDR_W = 16;

    function automatic logic [FFT_MAX_ADDR_W-1:0] bit_reverse(
        input logic [FFT_MAX_ADDR_W-1:0] addr,
        input int                        width
    );
        logic [FFT_MAX_ADDR_W-1:0] rev;
        rev = '0;
        for (int i = 0; i < FFT_MAX_ADDR_W; i++) begin
            if (i < width) begin
                rev[i] = addr[width-1-i];
            end
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_mem_bank.sv
// One DEPTH x DATA_W sample bank with two write ports and two registered
// read ports.
//   clk, rst                    : clock, synchronous active-high reset
//                                 (resets only the read data registers)
//   we_1/waddr_1/wdata_1        : write port 1
//   we_2/waddr_2/wdata_2        : write port 2, wins on an address clash
//   re_1/raddr_1 -> rdata_1     : read port 1, one-cycle latency, holds
//                                 its value while re_1 is low
//   re_2/raddr_2 -> rdata_2     : read port 2, same behaviour
module fft_mem_bank
    import fft_pingpong_mem_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] waddr_1,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic              we_2,
    input  logic [ADDR_W-1:0] waddr_2,
    input  logic [DATA_W-1:0] wdata_2,
    input  logic              re_1,
    input  logic [ADDR_W-1:0] raddr_1,
    output logic [DATA_W-1:0] rdata_1,
    input  logic              re_2,
    input  logic [ADDR_W-1:0] raddr_2,
    output logic [DATA_W-1:0] rdata_2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_1_q;
    logic [DATA_W-1:0] rdata_2_q;

    // Port 2 is written last, so on a shared address its value is the one
    // that remains.
    always_ff @(posedge clk) begin
        if (we_1) begin
            mem_q[waddr_1] <= wdata_1;
        end
        if (we_2) begin
            mem_q[waddr_2] <= wdata_2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_1_q <= '0;
            rdata_2_q <= '0;
        end else begin
            if (re_1) begin
                rdata_1_q <= mem_q[raddr_1];
            end
            if (re_2) begin
                rdata_2_q <= mem_q[raddr_2];
            end
        end
    end

    assign rdata_1 = rdata_1_q;
    assign rdata_2 = rdata_2_q;

endmodule

// File: rtl/fft_pingpong_mem.sv
// Double-buffered (ping-pong) FFT sample memory.  One bank is written while
// the other is read; the banks trade roles through a swap handshake that is
// only accepted once the write bank is full.
//   clk, rst                              : clock, sync active-high reset
//   wr_en_1/wr_addr_1/wr_data_1, bitrev_en: write port 1, optional
//                                           bit-reversed addressing
//   wr_en_2/wr_addr_2/wr_data_2           : write port 2 (wins on clash)
//   rd_en_n/rd_addr_n -> rd_data_n/rd_valid_n : registered read ports
//   swap_req -> swap_ack                  : bank exchange handshake
//   wr_bank, wr_count, wr_full            : write bank status
//   collision                             : pulse, both writes hit one address
module fft_pingpong_mem
    import fft_pingpong_mem_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_1,
    input  logic [ADDR_W-1:0] wr_addr_1,
    input  logic [DATA_W-1:0] wr_data_1,
    input  logic              wr_en_2,
    input  logic [ADDR_W-1:0] wr_addr_2,
    input  logic [DATA_W-1:0] wr_data_2,
    input  logic              bitrev_en,
    input  logic              rd_en_1,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic [DATA_W-1:0] rd_data_1,
    output logic              rd_valid_1,
    input  logic              rd_en_2,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_valid_2,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              wr_bank,
    output logic [ADDR_W:0]   wr_count,
    output logic              wr_full,
    output logic              collision
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic              wr_bank_q,    wr_bank_d;
    logic [ADDR_W:0]   wr_count_q,   wr_count_d;
    logic              swap_ack_q,   swap_ack_d;
    logic              collision_q,  collision_d;
    logic              rd_valid_1_q, rd_valid_1_d;
    logic              rd_valid_2_q, rd_valid_2_d;
    // Which bank each read port last fetched from; selects the bank output
    // register that currently holds that port's data.
    logic              rd_sel_1_q,   rd_sel_1_d;
    logic              rd_sel_2_q,   rd_sel_2_d;

    logic [FFT_MAX_ADDR_W-1:0] addr_1_wide;
    logic [FFT_MAX_ADDR_W-1:0] addr_1_rev;
    logic [ADDR_W-1:0]         wr_addr_1_eff;
    logic                      wr_full_now;
    logic                      swap_accept;
    logic                      clash;
    logic [1:0]                wr_inc;
    logic [ADDR_W+1:0]         count_sum;

    logic [DATA_W-1:0] bank_rdata_1 [2];
    logic [DATA_W-1:0] bank_rdata_2 [2];

    assign addr_1_wide   = FFT_MAX_ADDR_W'(wr_addr_1);
    assign addr_1_rev    = bit_reverse(addr_1_wide, ADDR_W);
    assign wr_addr_1_eff = bitrev_en ? addr_1_rev[ADDR_W-1:0] : wr_addr_1;

    assign wr_full_now = (wr_count_q == DEPTH_CNT);
    assign swap_accept = swap_req && wr_full_now;
    assign clash       = wr_en_1 && wr_en_2 && (wr_addr_1_eff == wr_addr_2);

    always_comb begin
        wr_bank_d    = wr_bank_q;
        wr_count_d   = wr_count_q;
        swap_ack_d   = 1'b0;
        collision_d  = clash;
        rd_valid_1_d = rd_en_1;
        rd_valid_2_d = rd_en_2;
        rd_sel_1_d   = rd_sel_1_q;
        rd_sel_2_d   = rd_sel_2_q;

        // A clash lands a single word, so it counts once.
        wr_inc    = clash ? 2'd1 : ({1'b0, wr_en_1} + {1'b0, wr_en_2});
        count_sum = {1'b0, wr_count_q} + (ADDR_W + 2)'(wr_inc);

        if (rd_en_1) begin
            rd_sel_1_d = ~wr_bank_q;
        end
        if (rd_en_2) begin
            rd_sel_2_d = ~wr_bank_q;
        end

        if (swap_accept) begin
            // Writes in the accepting cycle go to the old bank and are not
            // carried into the new bank's count.
            wr_bank_d  = ~wr_bank_q;
            wr_count_d = '0;
            swap_ack_d = 1'b1;
        end else if (count_sum > {1'b0, DEPTH_CNT}) begin
            wr_count_d = DEPTH_CNT;
        end else begin
            wr_count_d = count_sum[ADDR_W:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q    <= 1'b0;
            wr_count_q   <= '0;
            swap_ack_q   <= 1'b0;
            collision_q  <= 1'b0;
            rd_valid_1_q <= 1'b0;
            rd_valid_2_q <= 1'b0;
            rd_sel_1_q   <= 1'b0;
            rd_sel_2_q   <= 1'b0;
        end else begin
            wr_bank_q    <= wr_bank_d;
            wr_count_q   <= wr_count_d;
            swap_ack_q   <= swap_ack_d;
            collision_q  <= collision_d;
            rd_valid_1_q <= rd_valid_1_d;
            rd_valid_2_q <= rd_valid_2_d;
            rd_sel_1_q   <= rd_sel_1_d;
            rd_sel_2_q   <= rd_sel_2_d;
        end
    end

    // Bank gi is written while wr_bank selects it and read otherwise.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic bank_is_wr;
        assign bank_is_wr = (wr_bank_q == 1'(gi));

        fft_mem_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .we_1    (wr_en_1 && bank_is_wr),
            .waddr_1 (wr_addr_1_eff),
            .wdata_1 (wr_data_1),
            .we_2    (wr_en_2 && bank_is_wr),
            .waddr_2 (wr_addr_2),
            .wdata_2 (wr_data_2),
            .re_1    (rd_en_1 && !bank_is_wr),
            .raddr_1 (rd_addr_1),
            .rdata_1 (bank_rdata_1[gi]),
            .re_2    (rd_en_2 && !bank_is_wr),
            .raddr_2 (rd_addr_2),
            .rdata_2 (bank_rdata_2[gi])
        );
    end

    assign rd_data_1  = bank_rdata_1[rd_sel_1_q];
    assign rd_data_2  = bank_rdata_2[rd_sel_2_q];
    assign rd_valid_1 = rd_valid_1_q;
    assign rd_valid_2 = rd_valid_2_q;
    assign swap_ack   = swap_ack_q;
    assign wr_bank    = wr_bank_q;
    assign wr_count   = wr_count_q;
    assign wr_full    = wr_full_now;
    assign collision  = collision_q;

endmodule

// File: tb/tb_fft_pingpong_mem.sv
// Directed bench for fft_pingpong_mem (DATA_W=32, ADDR_W=4, DEPTH=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so every check sees the state left by the preceding edge.
module tb_fft_pingpong_mem;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en_1, wr_en_2, bitrev_en;
    logic [ADDR_W-1:0] wr_addr_1, wr_addr_2;
    logic [DATA_W-1:0] wr_data_1, wr_data_2;
    logic              rd_en_1, rd_en_2;
    logic [ADDR_W-1:0] rd_addr_1, rd_addr_2;
    logic [DATA_W-1:0] rd_data_1, rd_data_2;
    logic              rd_valid_1, rd_valid_2;
    logic              swap_req, swap_ack, wr_bank, wr_full, collision;
    logic [ADDR_W:0]   wr_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fft_pingpong_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en_1    (wr_en_1),
        .wr_addr_1  (wr_addr_1),
        .wr_data_1  (wr_data_1),
        .wr_en_2    (wr_en_2),
        .wr_addr_2  (wr_addr_2),
        .wr_data_2  (wr_data_2),
        .bitrev_en  (bitrev_en),
        .rd_en_1    (rd_en_1),
        .rd_addr_1  (rd_addr_1),
        .rd_data_1  (rd_data_1),
        .rd_valid_1 (rd_valid_1),
        .rd_en_2    (rd_en_2),
        .rd_addr_2  (rd_addr_2),
        .rd_data_2  (rd_data_2),
        .rd_valid_2 (rd_valid_2),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .wr_bank    (wr_bank),
        .wr_count   (wr_count),
        .wr_full    (wr_full),
        .collision  (collision)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en_1 = 1'b0; wr_en_2 = 1'b0; bitrev_en = 1'b0;
        rd_en_1 = 1'b0; rd_en_2 = 1'b0;
        wr_addr_1 = '0; wr_addr_2 = '0; wr_data_1 = '0; wr_data_2 = '0;
        rd_addr_1 = '0; rd_addr_2 = '0;
    endtask

    initial begin
        int n;
        idle_inputs();
        swap_req = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check_val("rst_wr_bank",   32'(wr_bank),    32'd0);
        check_val("rst_wr_count",  32'(wr_count),   32'd0);
        check_val("rst_wr_full",   32'(wr_full),    32'd0);
        check_val("rst_swap_ack",  32'(swap_ack),   32'd0);
        check_val("rst_collision", 32'(collision),  32'd0);
        check_val("rst_rd_valid1", 32'(rd_valid_1), 32'd0);
        check_val("rst_rd_data1",  rd_data_1,       32'd0);
        check_val("rst_rd_data2",  rd_data_2,       32'd0);

        // 1. Fill bank 0 through port 1 with 0x100+addr
        for (int a = 0; a < 16; a++) begin
            wr_en_1 = 1'b1; wr_addr_1 = 4'(a); wr_data_1 = 32'h100 + 32'(a);
            tick();
            if (a == 6) check_val("fill_count7", 32'(wr_count), 32'd7);
        end
        wr_en_1 = 1'b0;
        check_val("fill_count16", 32'(wr_count), 32'd16);
        check_val("fill_full",    32'(wr_full),  32'd1);
        check_val("fill_no_ack",  32'(swap_ack), 32'd0);
        // Overwrite while full: same value, count saturates
        wr_en_1 = 1'b1; wr_addr_1 = 4'd0; wr_data_1 = 32'h100;
        tick();
        wr_en_1 = 1'b0;
        check_val("sat_count", 32'(wr_count), 32'd16);

        // 2. Swap from full
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check_val("swap1_ack",   32'(swap_ack), 32'd1);
        check_val("swap1_bank",  32'(wr_bank),  32'd1);
        check_val("swap1_count", 32'(wr_count), 32'd0);
        check_val("swap1_full",  32'(wr_full),  32'd0);
        rd_en_1 = 1'b1; rd_addr_1 = 4'd5;
        rd_en_2 = 1'b1; rd_addr_2 = 4'd5;
        tick();
        rd_en_1 = 1'b0; rd_en_2 = 1'b0;
        check_val("swap1_ack_pulse", 32'(swap_ack), 32'd0);
        check_val("rd5_data1",  rd_data_1,        32'h105);
        check_val("rd5_valid1", 32'(rd_valid_1), 32'd1);
        check_val("rd5_data2",  rd_data_2,        32'h105);
        check_val("rd5_valid2", 32'(rd_valid_2), 32'd1);
        tick();
        check_val("rd_hold_valid1", 32'(rd_valid_1), 32'd0);
        check_val("rd_hold_data1",  rd_data_1,        32'h105);

        // 3. Bit-reversed write: addr 0001 lands at 1000
        bitrev_en = 1'b1; wr_en_1 = 1'b1; wr_addr_1 = 4'd1; wr_data_1 = 32'hAAAA;
        tick();
        idle_inputs();
        check_val("bitrev_count", 32'(wr_count), 32'd1);

        // 4. Clash on address 3, port 2 wins
        wr_en_1 = 1'b1; wr_addr_1 = 4'd3; wr_data_1 = 32'h11;
        wr_en_2 = 1'b1; wr_addr_2 = 4'd3; wr_data_2 = 32'h22;
        tick();
        idle_inputs();
        check_val("clash_collision", 32'(collision), 32'd1);
        check_val("clash_count",     32'(wr_count),  32'd2);
        tick();
        check_val("clash_pulse", 32'(collision), 32'd0);

        // 5. Fill remaining 14 addresses via port 2; swap_req held from count 7
        n = 2;
        for (int a = 0; a < 16; a++) begin
            if (a != 3 && a != 8) begin
                wr_en_2 = 1'b1; wr_addr_2 = 4'(a); wr_data_2 = 32'h200 + 32'(a);
                tick();
                n++;
                if (n == 7) begin
                    swap_req = 1'b1;
                end else if (n == 9) begin
                    check_val("early_no_ack",  32'(swap_ack), 32'd0);
                    check_val("early_bank",    32'(wr_bank),  32'd1);
                end
            end
        end
        wr_en_2 = 1'b0;
        check_val("fill2_count",  32'(wr_count), 32'd16);
        check_val("fill2_no_ack", 32'(swap_ack), 32'd0);
        tick();
        swap_req = 1'b0;
        check_val("swap2_ack",  32'(swap_ack), 32'd1);
        check_val("swap2_bank", 32'(wr_bank),  32'd0);

        rd_en_1 = 1'b1; rd_addr_1 = 4'd8;
        rd_en_2 = 1'b1; rd_addr_2 = 4'd3;
        tick();
        check_val("rd_bitrev8", rd_data_1, 32'hAAAA);
        check_val("rd_clash3",  rd_data_2, 32'h22);
        rd_addr_1 = 4'd1; rd_addr_2 = 4'd0;
        tick();
        idle_inputs();
        check_val("rd_p2w_1", rd_data_1, 32'h201);
        check_val("rd_p2w_0", rd_data_2, 32'h200);

        // 6. Fill bank 0 with both ports, then reset during the accepting edge
        for (int a = 0; a < 8; a++) begin
            wr_en_1 = 1'b1; wr_addr_1 = 4'(a);     wr_data_1 = 32'h300 + 32'(a);
            wr_en_2 = 1'b1; wr_addr_2 = 4'(a + 8); wr_data_2 = 32'h300 + 32'(a + 8);
            tick();
        end
        idle_inputs();
        check_val("dual_count16", 32'(wr_count), 32'd16);
        swap_req = 1'b1; rst = 1'b1; rd_en_1 = 1'b1; rd_addr_1 = 4'd2;
        tick();
        swap_req = 1'b0; rst = 1'b0; rd_en_1 = 1'b0;
        check_val("rst_acc_bank",   32'(wr_bank),    32'd0);
        check_val("rst_acc_count",  32'(wr_count),   32'd0);
        check_val("rst_acc_ack",    32'(swap_ack),   32'd0);
        check_val("rst_acc_valid1", 32'(rd_valid_1), 32'd0);
        check_val("rst_acc_data1",  rd_data_1,       32'd0);
        tick();
        check_val("rst_after_ack", 32'(swap_ack), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
